// File: rtl/alu_exec_ctrl_if.sv
// Execute-stage control bundle between the pipeline and alu_exec_ctrl.
// master: pipeline side. It drives the decode fields, issue and the operands.
// slave : alu_exec_ctrl side. It drives the ALU control, mult/div status and HI/LO.
interface alu_exec_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic [2:0]       aluop;
    logic [5:0]       funct;
    logic             issue;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [2:0]       gout;
    logic             jr;
    logic             notor;
    logic [1:0]       mfsel;
    logic             busy;
    logic             md_done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output aluop, funct, issue, rs_val, rt_val,
        input  gout, jr, notor, mfsel, busy, md_done, dz, hi, lo
    );

    modport slave (
        input  aluop, funct, issue, rs_val, rt_val,
        output gout, jr, notor, mfsel, busy, md_done, dz, hi, lo
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU control decode plus an iterative multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset : rising-edge clock and synchronous active-high reset.
//   bus        : slave side of alu_exec_ctrl_if.
//                Inputs: aluop, funct, issue, rs_val, rt_val.
//                Outputs: gout, jr, notor and mfsel, which are combinational decode.
//                Outputs: busy, md_done and dz, which are decoded from the FSM state.
//                Outputs: hi and lo, which are the committed architectural registers.
// WIDTH must be in the range 4..64.
module alu_exec_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_ctrl_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam logic [2:0]  OP_RTYPE = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               accept_c;
    logic               sgn_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH:0]     div_sub_c;
    logic               div_ge_c;
    logic               div_zero_c;
    logic [2*WIDTH-1:0] mul_fix_c;
    logic [WIDTH-1:0]   quo_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;
    logic [2:0]         gout_c;
    logic               jr_c;
    logic               notor_c;
    logic [1:0]         mfsel_c;

    // ALU control decode: purely from aluop/funct.
    always_comb begin
        gout_c  = 3'b010;
        jr_c    = 1'b0;
        notor_c = 1'b0;
        mfsel_c = 2'b00;
        case (bus.aluop)
            3'b000: gout_c = 3'b010;
            3'b001: gout_c = 3'b110;
            3'b011: gout_c = 3'b000;
            3'b100: gout_c = 3'b001;
            3'b101: gout_c = 3'b011;
            3'b110: gout_c = 3'b101;
            3'b111: gout_c = 3'b100;
            OP_RTYPE: begin
                case (bus.funct)
                    6'b001000: begin
                        jr_c   = 1'b1;
                        gout_c = 3'b000;
                    end
                    6'b100111: begin
                        gout_c  = 3'b001;
                        notor_c = 1'b1;
                    end
                    6'b100000: gout_c  = 3'b010;
                    6'b100010: gout_c  = 3'b110;
                    6'b100100: gout_c  = 3'b000;
                    6'b100101: gout_c  = 3'b001;
                    6'b101010: gout_c  = 3'b111;
                    6'b010000: mfsel_c = 2'b01;
                    6'b010010: mfsel_c = 2'b10;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // mult/multu/div/divu are funct 0110xx. funct[1] selects divide, and funct[0] selects unsigned.
    assign accept_c = (state == IDLE) && bus.issue && (bus.aluop == OP_RTYPE)
                      && (bus.funct[5:2] == 4'b0110);
    assign sgn_c    = ~bus.funct[0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: count out WIDTH iterations, then spend one cycle in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = bus.funct[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept_c) begin
            cnt <= CNT_W'(WIDTH);
        end else if ((state == MUL) || (state == DIV)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Shift-add step: {acc,q} accumulates the product. q starts as the multiplier magnitude.
    assign mul_sum_c   = {1'b0, acc} + (q[0] ? {1'b0, b_mag} : '0);
    // Restoring step: acc is the partial remainder. Dividend bits shift out of q's top, and quotient bits shift into its bottom.
    assign div_shift_c = {acc, q[WIDTH-1]};
    assign div_ge_c    = (div_shift_c >= {1'b0, b_mag});
    assign div_sub_c   = div_shift_c - {1'b0, b_mag};

    // Operand latch and iteration datapath. No reset is needed; the contents are only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            is_div <= bus.funct[1];
            a_neg  <= sgn_c & bus.rs_val[WIDTH-1];
            b_neg  <= sgn_c & bus.rt_val[WIDTH-1];
            a_raw  <= bus.rs_val;
            b_mag  <= (sgn_c & bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
            q      <= (sgn_c & bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
            acc    <= '0;
        end else if (state == MUL) begin
            acc <= mul_sum_c[WIDTH:1];
            q   <= {mul_sum_c[0], q[WIDTH-1:1]};
        end else if (state == DIV) begin
            acc <= div_ge_c ? div_sub_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], div_ge_c};
        end
    end

    // Sign fix-up applied to the magnitude results.
    // most-negative / -1 falls out naturally: the quotient magnitude is 2^(WIDTH-1), and negating it leaves it unchanged.
    assign mul_fix_c  = (a_neg ^ b_neg) ? -{acc, q} : {acc, q};
    assign quo_fix_c  = (a_neg ^ b_neg) ? -q : q;
    assign rem_fix_c  = a_neg ? -acc : acc;
    assign div_zero_c = (b_mag == '0);

    // HI/LO commit on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == DONE) begin
            if (!is_div) begin
                {hi_reg, lo_reg} <= mul_fix_c;
            end else if (div_zero_c) begin
                hi_reg <= a_raw;
                lo_reg <= '1;
            end else begin
                hi_reg <= rem_fix_c;
                lo_reg <= quo_fix_c;
            end
        end
    end

    assign bus.gout    = gout_c;
    assign bus.jr      = jr_c;
    assign bus.notor   = notor_c;
    assign bus.mfsel   = mfsel_c;
    assign bus.busy    = (state != IDLE);
    assign bus.md_done = (state == DONE);
    assign bus.dz      = (state == DONE) && is_div && div_zero_c;
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl (WIDTH=32). It pairs a behavioural model with directed and random stimulus.
module tb_alu_exec_ctrl;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.WIDTH(WIDTH)) bus ();
    alu_exec_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    // Model state: cycles of busy remaining, committed HI/LO, and the pending {dz,hi,lo}.
    int          m_left = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [64:0] m_res  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {gout, jr, notor, mfsel}.
    function automatic logic [6:0] dec_model(input logic [2:0] op, input logic [5:0] f);
        logic [2:0] gmap [8];
        gmap = '{3'b010, 3'b110, 3'b010, 3'b000, 3'b001, 3'b011, 3'b101, 3'b100};
        if (op != 3'b010) return {gmap[op], 4'b0000};
        case (f)
            6'b001000: return {3'b000, 1'b1, 1'b0, 2'b00};
            6'b100111: return {3'b001, 1'b0, 1'b1, 2'b00};
            6'b100000: return {3'b010, 4'b0000};
            6'b100010: return {3'b110, 4'b0000};
            6'b100100: return {3'b000, 4'b0000};
            6'b100101: return {3'b001, 4'b0000};
            6'b101010: return {3'b111, 4'b0000};
            6'b010000: return {3'b010, 2'b00, 2'b01};
            6'b010010: return {3'b010, 2'b00, 2'b10};
            default:   return {3'b010, 4'b0000};
        endcase
    endfunction

    // Architectural result {dz, hi, lo}, computed with plain integer arithmetic.
    function automatic logic [64:0] compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        if (!f[1]) begin
            if (!f[0]) p = 64'(sa * sb);
            else       p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == 32'b0) return {1'b1, a, 32'hFFFF_FFFF};
        if (!f[0])      return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        return {1'b0, a % b, a / b};
    endfunction

    // Model update.
    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
            m_left <= m_left - 1;
        end else if (bus.issue && bus.aluop == 3'b010 &&
                     bus.funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) begin
            m_res  <= compute(bus.funct, bus.rs_val, bus.rt_val);
            m_left <= WIDTH + 1;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [6:0] d;
            d = dec_model(bus.aluop, bus.funct);
            chk("gout",    64'(bus.gout),    64'(d[6:4]));
            chk("jr",      64'(bus.jr),      64'(d[3]));
            chk("notor",   64'(bus.notor),   64'(d[2]));
            chk("mfsel",   64'(bus.mfsel),   64'(d[1:0]));
            chk("busy",    64'(bus.busy),    64'(m_left != 0));
            chk("md_done", 64'(bus.md_done), 64'(m_left == 1));
            chk("dz",      64'(bus.dz),      64'((m_left == 1) && m_res[64]));
            chk("hi",      64'(bus.hi),      64'(m_hi));
            chk("lo",      64'(bus.lo),      64'(m_lo));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic iss,
                         input logic [31:0] a, input logic [31:0] b);
        bus.aluop  = op;
        bus.funct  = f;
        bus.issue  = iss;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, then optionally inject a second issue or a reset at a given busy cycle.
    task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int reset_at, input int exp_busy,
                          input logic [31:0] eh, input logic [31:0] el, input int exp_dz);
        int bcnt;
        int dcnt;
        int zcnt;
        bcnt = 0;
        dcnt = 0;
        zcnt = 0;
        drive(3'b010, f, 1'b1, a, b);
        cyc();
        for (int k = 0; k < 200 && bus.busy === 1'b1; k++) begin
            bcnt++;
            if (bus.md_done === 1'b1) dcnt++;
            if (bus.dz === 1'b1) zcnt++;
            if (bcnt == inject_at) drive(3'b010, 6'b011000, 1'b1, $urandom, $urandom);
            else                   drive(3'b010, 6'b100000, 1'b0, $urandom, $urandom);
            reset = (bcnt == reset_at);
            cyc();
        end
        reset = 1'b0;
        drive(3'b000, 6'b000000, 1'b0, 32'b0, 32'b0);
        chk({nm, " busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        chk({nm, " done_pulses"}, 64'(dcnt), 64'((reset_at > 0) ? 0 : 1));
        chk({nm, " dz_pulses"},   64'(zcnt), 64'(exp_dz));
        chk({nm, " hi"},          64'(bus.hi), 64'(eh));
        chk({nm, " lo"},          64'(bus.lo), 64'(el));
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rand_funct();
        logic [5:0] fl [9];
        int         r;
        fl = '{6'b001000, 6'b100111, 6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b101010, 6'b010000, 6'b010010};
        r = $urandom_range(0, 9);
        if (r < 5) return 6'(6'b011000 + 6'($urandom_range(0, 3)));
        if (r < 8) return fl[$urandom_range(0, 8)];
        return 6'($urandom);
    endfunction

    initial begin
        reset = 1'b1;
        drive(3'b000, 6'b000000, 1'b0, 32'b0, 32'b0);
        repeat (2) cyc();
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset hi",      64'(bus.hi),      64'h0);
        chk("reset lo",      64'(bus.lo),      64'h0);
        chk("reset busy",    64'(bus.busy),    64'h0);
        chk("reset md_done", 64'(bus.md_done), 64'h0);
        chk("reset dz",      64'(bus.dz),      64'h0);

        // Literal decode points.
        drive(3'b010, 6'b100111, 1'b0, 32'b0, 32'b0);
        #1;
        chk("nor gout",  64'(bus.gout),  64'h1);
        chk("nor notor", 64'(bus.notor), 64'h1);
        chk("nor jr",    64'(bus.jr),    64'h0);
        drive(3'b010, 6'b001000, 1'b0, 32'b0, 32'b0);
        #1;
        chk("jr jr",   64'(bus.jr),   64'h1);
        chk("jr gout", 64'(bus.gout), 64'h0);
        drive(3'b010, 6'b011000, 1'b0, 32'b0, 32'b0);
        #1;
        chk("mult jr",   64'(bus.jr),   64'h0);
        chk("mult gout", 64'(bus.gout), 64'h2);
        drive(3'b010, 6'b010010, 1'b0, 32'b0, 32'b0);
        #1;
        chk("mflo mfsel", 64'(bus.mfsel), 64'h2);
        drive(3'b111, 6'b001000, 1'b0, 32'b0, 32'b0);
        #1;
        chk("op111 gout", 64'(bus.gout), 64'h4);
        chk("op111 jr",   64'(bus.jr),   64'h0);
        cyc();

        run_op("mult_neg3x7",  6'b011000, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("divu_100_7",   6'b011011, 32'd100,       32'd7,         0, 0, 33, 32'h0000_0002, 32'h0000_000E, 0);
        run_op("div_neg7_2",   6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_by_zero",  6'b011010, 32'h0000_0005, 32'h0000_0000, 0, 0, 33, 32'h0000_0005, 32'hFFFF_FFFF, 1);
        run_op("div_overflow", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("multu_max",    6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 33, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("reset_abort",  6'b011000, 32'h0000_1234, 32'h0000_5678, 0, 10, 10, 32'h0, 32'h0, 0);
        run_op("mult_2x3",     6'b011000, 32'h0000_0002, 32'h0000_0003, 0, 0, 33, 32'h0000_0000, 32'h0000_0006, 0);

        // Random traffic, including mf/alu ops and mult/div issues while busy, plus occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
            drive(op, rand_funct(), ($urandom_range(0, 2) == 0), rand_val(), rand_val());
            reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0;
        drive(3'b000, 6'b000000, 1'b0, 32'b0, 32'b0);
        repeat (40) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath and HI/LO width; legal range 4..64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: aluop  input  3  ALU operation class from main control.
REQ-005 SHALL have port: funct  input  6  full R-type function field.
REQ-006 SHALL have port: issue  input  1  instruction valid in execute this cycle.
REQ-007 SHALL have ports: rs_val, rt_val  input  WIDTH  source operands.
REQ-008 SHALL have port: gout  output  3  ALU control code.
REQ-009 SHALL have ports: jr, notor  output  1 each  jump-register flag; NOR-invert flag.
REQ-010 SHALL have port: mfsel  output  2  move-from select: 00 none, 01 HI, 10 LO.
REQ-011 SHALL have port: busy  output  1  multiply/divide in progress; stall request.
REQ-012 SHALL have ports: md_done, dz  output  1 each  result-commit pulse; divide-by-zero flag valid with md_done.
REQ-013 SHALL have ports: hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 gout/jr/notor/mfsel SHALL be combinational from aluop/funct, independent of state and issue.
REQ-015 aluop map: 000->010; 101->011; 111->100; 110->101; 011->000; 100->001; 001->110; 010 = R-type decode.
REQ-016 R-type, full 6-bit funct: 001000 jr=1,gout=000; 100111 gout=001,notor=1; 100000 010; 100010 110; 100100 000; 100101 001; 101010 111.
REQ-017 R-type funct 010000 -> mfsel=01; 010010 -> mfsel=10; both gout=010.
REQ-018 Any other funct, incl. 011000-011011: gout=010, jr=0, notor=0, mfsel=00; jr/notor SHALL be 0 for every non-R-type aluop.
REQ-019 FSM states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-020 Accept when state=IDLE, issue=1, aluop=010, funct in {011000 mult, 011001 multu, 011010 div, 011011 divu}; latch rs_val, rt_val, signedness, op; later operand changes ignored.
REQ-021 Accept edge: IDLE->MUL (mult/multu) or DIV (div/divu); iteration counter loaded with WIDTH.
REQ-022 MUL: shift-add, one bit per cycle on operand magnitudes; DIV: restoring, one quotient bit per cycle; counter decrements; after WIDTH iteration edges -> DONE.
REQ-023 DONE lasts one cycle: md_done=1; signed sign fix-up applied; hi/lo written on edge leaving DONE; state -> IDLE.
REQ-024 Latency: busy high exactly WIDTH+1 cycles after accept edge; hi/lo hold new values from edge WIDTH+1 onward.
REQ-025 Multiply: {hi,lo} = full 2*WIDTH-bit product, two's complement when signed.
REQ-026 Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-027 Divide by zero: lo = all ones, hi = dividend (rs_val), dz=1 in DONE; dz=0 at all other times; full WIDTH+1 latency retained.
REQ-028 Signed overflow (most-negative / -1): lo = most-negative, hi = 0, dz=0.
REQ-029 issue with mult/div while busy SHALL be ignored (no restart, no queue); hi/lo unchanged until current op commits.
REQ-030 mfhi/mflo while busy: mfsel still decoded; pipeline holds on busy; hi/lo reflect only committed values.
REQ-031 hi/lo SHALL change only on commit edge or reset.

Reset
REQ-032 reset=1 at a rising edge: state IDLE, counter 0, hi=0, lo=0, busy=0, md_done=0, dz=0.
REQ-033 Reset mid-operation aborts the op with no hi/lo write; accept permitted in the first cycle after reset deasserts.
REQ-034 Reset has no effect on combinational decode outputs.

Verification (WIDTH=32)
REQ-035 aluop=010 funct=100111 -> gout=001 notor=1 jr=0; funct=001000 -> jr=1 gout=000; funct=011000 -> jr=0 gout=010.
REQ-036 mult rs=FFFFFFFD rt=00000007 -> busy 33 cycles, md_done one cycle, hi=FFFFFFFF lo=FFFFFFEB.
REQ-037 divu rs=100 rt=7 -> lo=0000000E hi=00000002; div rs=FFFFFFF9 rt=2 -> lo=FFFFFFFD hi=FFFFFFFF.
REQ-038 div rs=5 rt=0 -> dz=1 with md_done, lo=FFFFFFFF hi=00000005; div rs=80000000 rt=FFFFFFFF -> lo=80000000 hi=0.
REQ-039 multu FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001; second mult issued at busy cycle 5 ignored.
REQ-040 reset at busy cycle 10 -> next cycle busy=0 hi=lo=0; immediate new mult 2*3 -> lo=6 hi=0 after 33 cycles.
